// File: rtl/edge_det_pkg.sv
// edge_det_pkg
// Shared types and constants for the multi-channel edge detector:
//   arm_state_e - arming FSM state encoding (ARMING, ACTIVE)
//   DEF_*       - default parameter values for the top level
//   cnt_width() - bits needed to hold a count of 0..max_val
package edge_det_pkg;

    typedef enum logic {
        ARMING = 1'b0,
        ACTIVE = 1'b1
    } arm_state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_PULSE_CYCLES = 1;

    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// edge_det_channel
// One detector channel: input synchroniser, history flop, pulse-stretch
// down-counter and sticky pending flag.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   active_i     arming complete; edges only qualify when high
//   sig_i        raw level input (may be asynchronous)
//   rise_en_i    qualify 0->1 transitions
//   fall_en_i    qualify 1->0 transitions
//   clear_i      write-1-to-clear for the pending flag
//   pulse_o      stretched pulse, PULSE_CYCLES long after the last edge
//   pending_o    sticky flag set by a qualifying edge
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_DEPTH   = 1,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic sig_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic clear_i,
    output logic pulse_o,
    output logic pending_o
);

    localparam int CW = cnt_width(PULSE_CYCLES);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  hist_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  s, rise, fall, qual;

    assign s    = sync_q[SYNC_DEPTH-1];
    assign rise = s & ~hist_q;
    assign fall = ~s & hist_q;
    // Enables are used combinationally in the detection cycle.
    assign qual = active_i & ((rise & rise_en_i) | (fall & fall_en_i));

    always_comb begin
        cnt_d = cnt_q;
        if (qual)
            cnt_d = CW'(PULSE_CYCLES);   // retrigger restarts the full stretch
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        // A new edge beats a simultaneous clear.
        pend_d = qual | (pend_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q[0] <= sig_i;
            for (int i = 1; i < SYNC_DEPTH; i++)
                sync_q[i] <= sync_q[i-1];
            hist_q <= s;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pulse_o   = (cnt_q != '0);
    assign pending_o = pend_q;

endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
// WIDTH independent edge-detect channels with pulse stretching, sticky
// pending flags and a shared arming FSM that masks start-up transients.
// Build option: define EDGE_DET_SYNC_EN for a SYNC_STAGES-deep synchroniser
// per channel; otherwise each channel uses a single sample flop.
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   signal_in      raw level inputs
//   rise_en        per-channel rising-edge enable
//   fall_en        per-channel falling-edge enable
//   event_clear    per-channel write-1-to-clear of event_pending
//   pulse_out      per-channel stretched pulse
//   event_pending  per-channel sticky event flag
//   any_pending    registered OR of event_pending
//
// state  | meaning
// -------+---------------------------------------------------------------
// ARMING | pipeline filling after reset; history tracks input, no edges
// ACTIVE | normal detection
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] event_clear,
    output logic [WIDTH-1:0] pulse_out,
    output logic [WIDTH-1:0] event_pending,
    output logic             any_pending
);

`ifdef EDGE_DET_SYNC_EN
    localparam int N = SYNC_STAGES;
`else
    localparam int N = 1;
`endif

    localparam int ACW = cnt_width(N);

    if (WIDTH < 1)        $error("WIDTH must be >= 1");
    if (SYNC_STAGES < 2)  $error("SYNC_STAGES must be >= 2");
    if (PULSE_CYCLES < 1) $error("PULSE_CYCLES must be >= 1");

    arm_state_e       state_q;
    logic [ACW-1:0]   arm_cnt_q;
    logic             any_q;
    logic [WIDTH-1:0] pend_w;

    // Arming holds for N+1 cycles: N to fill the sample pipeline plus one
    // so history matches the first valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARMING;
            arm_cnt_q <= '0;
            any_q     <= 1'b0;
        end else begin
            case (state_q)
                ARMING: begin
                    if (arm_cnt_q == ACW'(N))
                        state_q <= ACTIVE;
                    else
                        arm_cnt_q <= arm_cnt_q + ACW'(1);
                end
                default: state_q <= ACTIVE;
            endcase
            any_q <= |pend_w;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        edge_det_channel #(
            .SYNC_DEPTH   (N),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .active_i  (state_q == ACTIVE),
            .sig_i     (signal_in[g]),
            .rise_en_i (rise_en[g]),
            .fall_en_i (fall_en[g]),
            .clear_i   (event_clear[g]),
            .pulse_o   (pulse_out[g]),
            .pending_o (pend_w[g])
        );
    end

    assign event_pending = pend_w;
    assign any_pending   = any_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

`ifdef EDGE_DET_SYNC_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] signal_in, rise_en, fall_en, event_clear;
    logic [7:0] p1_pulse, p1_pend, p4_pulse, p4_pend;
    logic       p1_any, p4_any;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .PULSE_CYCLES(1)) dut_p1 (
        .clk           (clk),
        .rst           (rst),
        .signal_in     (signal_in),
        .rise_en       (rise_en),
        .fall_en       (fall_en),
        .event_clear   (event_clear),
        .pulse_out     (p1_pulse),
        .event_pending (p1_pend),
        .any_pending   (p1_any)
    );

    multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .PULSE_CYCLES(4)) dut_p4 (
        .clk           (clk),
        .rst           (rst),
        .signal_in     (signal_in),
        .rise_en       (rise_en),
        .fall_en       (fall_en),
        .event_clear   (event_clear),
        .pulse_out     (p4_pulse),
        .event_pending (p4_pend),
        .any_pending   (p4_any)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic reset_dut(input logic [7:0] sig);
        signal_in   = sig;
        event_clear = 8'h00;
        rst         = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (N + 3) tick();
    endtask

    initial begin
        int hi, runs;
        logic prev;
        logic [7:0] acc;

        rst = 1'b1; signal_in = 8'h00; rise_en = 8'hFF; fall_en = 8'h00; event_clear = 8'h00;

        // reset state
        repeat (2) tick();
        check("rst_pulse", p1_pulse, 8'h00);
        check("rst_pend", p1_pend, 8'h00);
        check("rst_any", p1_any, 1'b0);
        check("rst_pulse4", p4_pulse, 8'h00);

        // single rising edge on ch0, pulse after edge N for one cycle
        rise_en = 8'hFF; fall_en = 8'h00;
        reset_dut(8'h00);
        signal_in = 8'h01;
        for (int k = 0; k <= N; k++) begin
            tick();
            check($sformatf("rise_lat_e%0d", k), p1_pulse, (k == N) ? 8'h01 : 8'h00);
        end
        check("rise_pend", p1_pend, 8'h01);
        check("rise_any_lag", p1_any, 1'b0);
        tick();
        check("rise_pulse_end", p1_pulse, 8'h00);
        check("rise_any", p1_any, 1'b1);

        // fall-only on ch1; input held high through reset
        rise_en = 8'h00; fall_en = 8'h02;
        reset_dut(8'h02);
        check("fall_idle_pend", p1_pend, 8'h00);
        signal_in = 8'h00;
        hi = 0;
        for (int i = 0; i < N + 5; i++) begin
            tick();
            if (p1_pulse != 8'h00) hi++;
        end
        check("fall_pulses", hi, 1);
        check("fall_pend", p1_pend, 8'h02);
        event_clear = 8'h02;
        tick();
        event_clear = 8'h00;
        check("fall_clr", p1_pend, 8'h00);
        signal_in = 8'h02;
        hi = 0;
        for (int i = 0; i < N + 5; i++) begin
            tick();
            if (p1_pulse != 8'h00) hi++;
        end
        check("fall_rise_nopulse", hi, 0);
        check("fall_rise_nopend", p1_pend, 8'h00);

        // retrigger: two edges two cycles apart
        rise_en = 8'h01; fall_en = 8'h01;
        reset_dut(8'h00);
        signal_in = 8'h01;
        hi = 0; runs = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 1) signal_in = 8'h00;
            if (p4_pulse[0]) hi++;
            if (p4_pulse[0] && !prev) runs++;
            prev = p4_pulse[0];
        end
        check("retrig_len", hi, 6);
        check("retrig_runs", runs, 1);

        // same stimulus on the 1-cycle instance: two separate pulses
        reset_dut(8'h00);
        signal_in = 8'h01;
        hi = 0; runs = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 1) signal_in = 8'h00;
            if (p1_pulse[0]) hi++;
            if (p1_pulse[0] && !prev) runs++;
            prev = p1_pulse[0];
        end
        check("p1_two_len", hi, 2);
        check("p1_two_runs", runs, 2);

        // toggle every cycle, both edges enabled: pulse every cycle
        rise_en = 8'hFF; fall_en = 8'hFF;
        reset_dut(8'h00);
        hi = 0; runs = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) signal_in[0] = ~signal_in[0];
            tick();
            if (p1_pulse[0]) hi++;
            if (p1_pulse[0] && !prev) runs++;
            prev = p1_pulse[0];
        end
        check("toggle_len", hi, 8);
        check("toggle_runs", runs, 1);

        // clear vs new edge in the same cycle, then clear alone
        reset_dut(8'h00);
        signal_in = 8'h01;
        repeat (N + 1) tick();
        check("clr_pre_pend", p1_pend, 8'h01);
        signal_in = 8'h00;
        repeat (N) tick();
        event_clear = 8'h01;
        tick();
        event_clear = 8'h00;
        check("clr_set_wins", p1_pend, 8'h01);
        event_clear = 8'h01;
        tick();
        event_clear = 8'h00;
        check("clr_alone", p1_pend, 8'h00);
        check("clr_any_lag", p1_any, 1'b1);
        tick();
        check("clr_any", p1_any, 1'b0);

        // input high through reset release: no edge reported
        rise_en = 8'hFF; fall_en = 8'hFF;
        signal_in = 8'hFF;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        acc = 8'h00;
        for (int i = 0; i < N + 6; i++) begin
            tick();
            acc = acc | p1_pulse | p1_pend | p4_pulse | p4_pend;
        end
        check("hold_high_quiet", acc, 8'h00);

        // reset mid-pulse
        rise_en = 8'hFF; fall_en = 8'h00;
        reset_dut(8'h00);
        signal_in = 8'h01;
        repeat (N + 1) tick();
        check("mid_pulse_on", p4_pulse, 8'h01);
        rst = 1'b1;
        tick();
        check("mid_rst_pulse", p4_pulse, 8'h00);
        check("mid_rst_pend", p4_pend, 8'h00);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p4_pulse != 8'h00) hi++;
        end
        check("mid_rst_residual", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth N when EDGE_DET_SYNC_EN is defined (>=2).
REQ-003 Parameter PULSE_CYCLES, default 1, output pulse length in cycles (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 signal_in  input  WIDTH  raw level inputs, may be asynchronous to clk.
REQ-007 rise_en  input  WIDTH  per-channel: detect 0->1 transitions.
REQ-008 fall_en  input  WIDTH  per-channel: detect 1->0 transitions.
REQ-009 event_clear  input  WIDTH  per-channel write-1-to-clear for event_pending.
REQ-010 pulse_out  output  WIDTH  per-channel registered pulse, PULSE_CYCLES wide.
REQ-011 event_pending  output  WIDTH  per-channel sticky flag, set by a qualifying edge.
REQ-012 any_pending  output  1  registered OR of event_pending.

Function
REQ-013 Sampled value s: N-flop synchroniser output (macro defined) or single input flop (macro undefined, N=1).
REQ-014 History flop h holds the previous s; rise = s & ~h, fall = ~s & h; qualifying edge = (rise & rise_en) | (fall & fall_en).
REQ-015 Latency: input level first sampled at edge 0 -> pulse_out high after edge N (N+1 edges inclusive).
REQ-016 Per-channel down-counter, width clog2(PULSE_CYCLES+1); qualifying edge loads PULSE_CYCLES; pulse_out = (counter != 0), registered.
REQ-017 Qualifying edge while counter nonzero reloads to PULSE_CYCLES (retrigger); no pulse concatenation beyond PULSE_CYCLES after the last edge.
REQ-018 PULSE_CYCLES=1 with an input toggling every cycle: pulse_out high every cycle an edge qualifies.
REQ-019 rise_en=fall_en=0: channel produces no pulse and no pending; history still tracks s.
REQ-020 rise_en/fall_en sampled in the same cycle as detection; no registering of mode.
REQ-021 event_pending set on the edge following a qualifying edge; cleared by event_clear; set and clear in same cycle -> set wins.
REQ-022 any_pending updates one cycle after event_pending.
REQ-023 Arming FSM, shared: ARMING -> ACTIVE after N+1 cycles out of reset; in ARMING, h loads s each cycle, no edges qualify.

Reset
REQ-024 rst high: synchroniser, h, counters, pulse_out, event_pending, any_pending all 0; FSM to ARMING, arming count 0.
REQ-025 rst asserted mid-pulse: pulse_out 0 on next edge; no residual pulse after release.
REQ-026 Input held high through reset release: no rising edge reported (suppressed by ARMING).

Configuration
REQ-027 Macro EDGE_DET_SYNC_EN defined: N-stage synchroniser per channel, SYNC_STAGES honoured.
REQ-028 Macro undefined: single sample flop, SYNC_STAGES ignored, latency 2 edges, ARMING lasts 2 cycles.

Structure
REQ-029 Package edge_det_pkg: FSM state typedef (ARMING, ACTIVE), default parameter constants, counter-width function.
REQ-030 Sub-module edge_det_channel: sync, history, stretch counter, sticky flag for one channel; generated WIDTH times; FSM and any_pending in top.

Verification
REQ-031 WIDTH=8, N=2, PULSE_CYCLES=1, rise_en=0xFF: ch0 0->1 at edge 0 -> pulse_out=0x01 for exactly one cycle after edge 2; event_pending[0]=1.
REQ-032 fall_en=0x02 only: ch1 1->0 -> one pulse; ch1 0->1 -> no pulse, no pending.
REQ-033 PULSE_CYCLES=4: edge, second edge 2 cycles later -> pulse_out high 6 contiguous cycles.
REQ-034 event_clear[0] same cycle as new ch0 edge -> event_pending[0] stays 1; clear alone -> 0, any_pending 0 next cycle.
REQ-035 signal_in=0xFF through reset release -> pulse_out, event_pending remain 0x00; rst mid-pulse -> pulse_out 0 next edge.
REQ-036 Rerun REQ-031 with EDGE_DET_SYNC_EN undefined -> pulse after edge 1.
